// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU, quotient to lo_o and remainder to hi_o.
// `DIV_ZERO_FAST_EN: a zero divisor goes straight from IDLE to DONE instead of running 32 CALC steps.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        annul_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] quot_q, quot_d;
  logic [32:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        ready_q, ready_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, trial, rem_step;
  logic        fits;
  logic [31:0] quot_step, lo_fin, hi_fin;

  // Operand magnitudes; for DIVU the raw bits are already the magnitude.
  always_comb begin
    a_neg = signed_i & a_i[31];
    b_neg = signed_i & b_i[31];
    a_mag = a_neg ? (32'd0 - a_i) : a_i;
    b_mag = b_neg ? (32'd0 - b_i) : b_i;
  end

  // One restoring step: bring in the next dividend bit, subtract if the divisor fits.
  always_comb begin
    shifted   = (rem_q << 1) | {32'd0, quot_q[31]};
    trial     = shifted - {1'b0, divisor_q};
    fits      = (shifted >= {1'b0, divisor_q});
    rem_step  = fits ? trial : shifted;
    quot_step = {quot_q[30:0], fits};
    lo_fin    = neg_quot_q ? (32'd0 - quot_step) : quot_step;
    hi_fin    = neg_rem_q ? (32'd0 - rem_step[31:0]) : rem_step[31:0];
  end

  always_comb begin
    state_d    = state_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    ready_d    = 1'b0;
    stall_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          stall_o    = 1'b1;
          divisor_d  = b_mag;
          quot_d     = a_mag;
          rem_d      = '0;
          cnt_d      = '0;
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
`ifdef DIV_ZERO_FAST_EN
          if (b_i == 32'd0) begin
            // Same values the full-length path would produce for a zero divisor.
            state_d = DONE;
            ready_d = 1'b1;
            lo_d    = a_neg ? 32'd1 : 32'hFFFF_FFFF;
            hi_d    = a_i;
          end else begin
            state_d = CALC;
          end
`else
          state_d = CALC;
`endif
        end
      end

      CALC: begin
        stall_o = 1'b1;
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d  = rem_step;
          quot_d = quot_step;
          cnt_d  = cnt_q + 6'd1;
          // Results are written on the last step so they are valid while ready_o is high.
          if (cnt_q == 6'd31) begin
            state_d = DONE;
            ready_d = 1'b1;
            hi_d    = hi_fin;
            lo_d    = lo_fin;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      ready_q    <= ready_d;
    end
  end

  assign busy_o  = (state_q == CALC);
  assign ready_o = ready_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: arithmetic reference model with a timeline of the expected handshake,
// one per-cycle compare process, directed literal cases and a randomized phase.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, annul_i;
  logic [31:0] a_i, b_i;
  logic        stall_o, busy_o, ready_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul_i  (annul_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .ready_o  (ready_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_ZERO = 1'b1;
`else
  localparam bit FAST_ZERO = 1'b0;
`endif

  // Architectural result: truncating division, remainder takes the dividend's sign.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      r = a;
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Timeline model: an accepted divide occupies cycles t_start..t_done.
  int          cyc = 0;
  bit          act = 1'b0;
  int          t_start = 0, t_done = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0, pend_hi, pend_lo;

  always @(posedge clk) begin
    if (rst) begin
      act    = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
    end else if (act) begin
      if (cyc == t_done) act = 1'b0;
      else if (annul_i && cyc > t_start) act = 1'b0;
      else if (cyc + 1 == t_done) begin
        exp_hi = pend_hi;
        exp_lo = pend_lo;
      end
    end else if (start_i && !annul_i) begin
      ref_div(signed_i, a_i, b_i, pend_lo, pend_hi);
      act     = 1'b1;
      t_start = cyc;
      t_done  = cyc + ((FAST_ZERO && b_i == 32'd0) ? 1 : 33);
      if (t_done == cyc + 1) begin
        exp_hi = pend_hi;
        exp_lo = pend_lo;
      end
    end
    cyc++;
  end

  // Literal expectations from the directed sequence are queued and judged by the compare process.
  string       lit_name[$];
  logic [31:0] lit_act[$], lit_exp[$];

  task automatic lit(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    lit_name.push_back(nm);
    lit_act.push_back(act_v);
    lit_exp.push_back(exp_v);
  endtask

  logic        m_busy, m_ready, m_stall;
  logic [31:0] m_hi, m_lo;
  string       c_nm;
  logic [31:0] c_a, c_e;

  always @(negedge clk) begin
    while (lit_name.size() > 0) begin
      c_nm = lit_name.pop_front();
      c_a  = lit_act.pop_front();
      c_e  = lit_exp.pop_front();
      total++;
      if (c_a !== c_e) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", c_nm, c_a, c_e);
      end
    end
    if (rst) begin
      m_busy = 1'b0; m_ready = 1'b0; m_hi = '0; m_lo = '0;
      m_stall = start_i & ~annul_i;
    end else begin
      m_busy  = act && cyc > t_start && cyc < t_done;
      m_ready = act && cyc == t_done;
      m_stall = m_busy | (!act & start_i & ~annul_i);
      m_hi    = exp_hi;
      m_lo    = exp_lo;
    end
    total += 5;
    if (busy_o !== m_busy)   begin bad++; $display("FAIL busy cyc=%0d: got=%b want=%b", cyc, busy_o, m_busy); end
    if (ready_o !== m_ready) begin bad++; $display("FAIL ready cyc=%0d: got=%b want=%b", cyc, ready_o, m_ready); end
    if (stall_o !== m_stall) begin bad++; $display("FAIL stall cyc=%0d: got=%b want=%b", cyc, stall_o, m_stall); end
    if (hi_o !== m_hi)       begin bad++; $display("FAIL hi cyc=%0d: got=%h want=%h", cyc, hi_o, m_hi); end
    if (lo_o !== m_lo)       begin bad++; $display("FAIL lo cyc=%0d: got=%h want=%h", cyc, lo_o, m_lo); end
  end

  // Issue one divide from an idle unit and wait (bounded) for its ready pulse.
  task automatic do_div(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi, input int elat);
    int lat = 0;
    start_i = 1'b1; signed_i = s; a_i = a; b_i = b;
    @(negedge clk);
    lit({nm, "_stall0"}, {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (ready_o) begin
        lat = i;
        lit({nm, "_lo"}, lo_o, elo);
        lit({nm, "_hi"}, hi_o, ehi);
      end
      @(posedge clk); #1;
    end
    lit({nm, "_latency"}, lat, elat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ready_seen;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    lit("rst_busy", {31'd0, busy_o}, 32'd0);
    lit("rst_ready", {31'd0, ready_o}, 32'd0);
    lit("rst_hi", hi_o, 32'd0);
    lit("rst_lo", lo_o, 32'd0);
    start_i = 1'b1;
    #1;
    lit("rst_stall_follows_start", {31'd0, stall_o}, 32'd1);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    do_div("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    do_div("div_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, FAST_ZERO ? 1 : 33);
    do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, FAST_ZERO ? 1 : 33);
    do_div("divu_100_7b", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

    // Annul mid-CALC with start_i held high throughout.
    ready_seen = 0;
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd50; b_i = 32'd3;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 10) annul_i = 1'b1;
      if (c == 11) begin annul_i = 1'b0; start_i = 1'b0; end
      @(negedge clk);
      if (ready_o) ready_seen++;
      if (c == 11) lit("annul_busy_c11", {31'd0, busy_o}, 32'd0);
    end
    lit("annul_no_ready", ready_seen, 32'd0);
    lit("annul_hi_kept", hi_o, 32'd2);
    lit("annul_lo_kept", lo_o, 32'd14);
    @(posedge clk); #1;

    // Reset in cycle 15 of a divide.
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    lit("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    #1;
    lit("midrst_busy", {31'd0, busy_o}, 32'd0);
    lit("midrst_ready", {31'd0, ready_o}, 32'd0);
    lit("midrst_hi", hi_o, 32'd0);
    lit("midrst_lo", lo_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Randomized traffic; the compare process judges every cycle.
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 599) == 0);
      start_i  = ($urandom_range(0, 9) < 3);
      annul_i  = ($urandom_range(0, 39) == 0);
      signed_i = $urandom_range(0, 1);
      a_i      = pick();
      b_i      = pick();
      @(posedge clk); #1;
    end
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
